// File: rtl/hyper_readback_checker.sv
// Read-back verifier for HyperRAM: issues burst reads over a range and checks
// each returned dword against the incrementing pattern (addr + PATTERN_OFFSET).
module hyper_readback_checker #(
  parameter logic [31:0] PATTERN_OFFSET = 32'h0,
  parameter int          MAX_BURST      = 32,
  parameter int          TIMEOUT_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] base_addr,
  input  logic [15:0] num_dwords,
  input  logic [5:0]  burst_len,
  output logic        rd_req,
  output logic [31:0] rd_addr,
  output logic [5:0]  rd_num_dwords,
  input  logic [31:0] rd_d,
  input  logic        rd_rdy,
  input  logic        busy,
  output logic        active,
  output logic        done,
  output logic        pass,
  output logic [15:0] err_count,
  output logic [31:0] first_err_addr,
  output logic [31:0] first_err_data,
  output logic        timeout
);

  typedef enum logic [2:0] {IDLE, ISSUE, COLLECT, DRAIN, FINISH} state_e;

  localparam int          TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [5:0]  MAX_B    = 6'(MAX_BURST);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_e        state_q, state_d;
  logic [31:0]   cur_addr_q, cur_addr_d;
  logic [15:0]   remaining_q, remaining_d;
  logic [5:0]    beats_left_q, beats_left_d;
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          rd_req_q, rd_req_d;
  logic [31:0]   rd_addr_q, rd_addr_d;
  logic [5:0]    rd_num_q, rd_num_d;
  logic [15:0]   err_count_q, err_count_d;
  logic [31:0]   first_err_addr_q, first_err_addr_d;
  logic [31:0]   first_err_data_q, first_err_data_d;
  logic          timeout_q, timeout_d;
  logic          pass_q, pass_d;

  logic [5:0]    eff;
  logic [5:0]    req_n;

  // Burst size for the next request: clamp to [1, MAX_BURST], then trim to what's left.
  always_comb begin
    eff = burst_len;
    if (burst_len == 6'd0)  eff = 6'd1;
    else if (burst_len > MAX_B) eff = MAX_B;
    req_n = (remaining_q < {10'd0, eff}) ? remaining_q[5:0] : eff;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= IDLE;
      cur_addr_q       <= '0;
      remaining_q      <= '0;
      beats_left_q     <= '0;
      tmo_cnt_q        <= '0;
      rd_req_q         <= 1'b0;
      rd_addr_q        <= '0;
      rd_num_q         <= '0;
      err_count_q      <= '0;
      first_err_addr_q <= '0;
      first_err_data_q <= '0;
      timeout_q        <= 1'b0;
      pass_q           <= 1'b0;
    end else begin
      state_q          <= state_d;
      cur_addr_q       <= cur_addr_d;
      remaining_q      <= remaining_d;
      beats_left_q     <= beats_left_d;
      tmo_cnt_q        <= tmo_cnt_d;
      rd_req_q         <= rd_req_d;
      rd_addr_q        <= rd_addr_d;
      rd_num_q         <= rd_num_d;
      err_count_q      <= err_count_d;
      first_err_addr_q <= first_err_addr_d;
      first_err_data_q <= first_err_data_d;
      timeout_q        <= timeout_d;
      pass_q           <= pass_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (num_dwords == 16'd0) ? FINISH : ISSUE;
      ISSUE:   if (!busy) state_d = COLLECT;
      COLLECT: begin
        if (rd_rdy) begin
          if (beats_left_q == 6'd1) state_d = DRAIN;
        end else if (tmo_cnt_q == TMO_LAST) begin
          state_d = FINISH;
        end
      end
      DRAIN:   if (!busy) state_d = (remaining_q != 16'd0) ? ISSUE : FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cur_addr_d       = cur_addr_q;
    remaining_d      = remaining_q;
    beats_left_d     = beats_left_q;
    tmo_cnt_d        = tmo_cnt_q;
    rd_req_d         = 1'b0;
    rd_addr_d        = rd_addr_q;
    rd_num_d         = rd_num_q;
    err_count_d      = err_count_q;
    first_err_addr_d = first_err_addr_q;
    first_err_data_d = first_err_data_q;
    timeout_d        = timeout_q;
    pass_d           = pass_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          cur_addr_d       = base_addr;
          remaining_d      = num_dwords;
          err_count_d      = '0;
          first_err_addr_d = '0;
          first_err_data_d = '0;
          timeout_d        = 1'b0;
          pass_d           = 1'b0;
        end
      end
      ISSUE: begin
        if (!busy) begin
          rd_req_d     = 1'b1;
          rd_addr_d    = cur_addr_q;
          rd_num_d     = req_n;
          beats_left_d = req_n;
          tmo_cnt_d    = '0;
        end
      end
      COLLECT: begin
        if (rd_rdy) begin
          if (rd_d != cur_addr_q + PATTERN_OFFSET) begin
            if (err_count_q != 16'hFFFF) err_count_d = err_count_q + 16'd1;
            if (err_count_q == 16'd0) begin
              first_err_addr_d = cur_addr_q;
              first_err_data_d = rd_d;
            end
          end
          cur_addr_d   = cur_addr_q + 32'd1;
          remaining_d  = remaining_q - 16'd1;
          beats_left_d = beats_left_q - 6'd1;
          tmo_cnt_d    = '0;
        end else if (tmo_cnt_q == TMO_LAST) begin
          timeout_d = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TW'(1);
        end
      end
      default: ;
    endcase
    // Result is fixed on entry to FINISH so it is already valid alongside done.
    if (state_d == FINISH && state_q != FINISH)
      pass_d = (err_count_d == 16'd0) && !timeout_d;
  end

  always_comb begin
    rd_req         = rd_req_q;
    rd_addr        = rd_addr_q;
    rd_num_dwords  = rd_num_q;
    active         = (state_q == ISSUE) || (state_q == COLLECT) || (state_q == DRAIN);
    done           = (state_q == FINISH);
    pass           = pass_q;
    err_count      = err_count_q;
    first_err_addr = first_err_addr_q;
    first_err_data = first_err_data_q;
    timeout        = timeout_q;
  end

endmodule

// File: doc/hyper_readback_checker.md
Name: hyper_readback_checker

Overview:
Read-back verifier for HyperRAM, driving the read side of hyper_xface. It pairs with the incrementing-pattern writer: issues burst reads over an address range and compares each returned dword against the expected pattern (data = address + PATTERN_OFFSET). It reports pass/fail, an error count, the first failing address/data, and a timeout flag. It sits beside the writer in top and shares the hyper_xface command port through an external mux.

Parameters:
PATTERN_OFFSET, 32'h0, added to beat address to form the expected data (mod 2^32)
MAX_BURST, 32, upper clamp on dwords per read request (1..63)
TIMEOUT_CYCLES, 4096, idle cycles allowed while waiting for a read beat before aborting

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse; begins a check run (ignored unless idle)
base_addr  in  32  first dword address of the run
num_dwords  in  16  total dwords to check
burst_len  in  6  requested dwords per read request
rd_req  out  1  read request pulse to hyper_xface
rd_addr  out  32  read address to hyper_xface
rd_num_dwords  out  6  dwords in this request
rd_d  in  32  read data from hyper_xface
rd_rdy  in  1  one-cycle strobe per valid rd_d dword
busy  in  1  hyper_xface busy
active  out  1  high from accepted start until done
done  out  1  one-cycle pulse at end of run
pass  out  1  run result, valid from done until next start
err_count  out  16  mismatch count, saturating at 16'hFFFF
first_err_addr  out  32  address of first mismatch
first_err_data  out  32  data read at first mismatch
timeout  out  1  run aborted on beat timeout

Behaviour:
- Reset: every output 0, state IDLE, internal counters 0. Reset mid-run returns to IDLE on the next cycle with rd_req=0; in-flight beats are ignored.
- States: IDLE, ISSUE, COLLECT, DRAIN, FINISH.
- IDLE + start:
  - Latch cur_addr=base_addr and remaining=num_dwords.
  - Clear err_count, first_err_*, timeout and pass.
  - Set active=1.
  - If num_dwords==0, go to FINISH; otherwise go to ISSUE.
  - start in any state other than IDLE is ignored.
- Effective burst: eff = burst_len clamped to [1, MAX_BURST]; burst_len==0 is treated as 1.
- ISSUE: wait for busy==0, then assert rd_req for exactly one cycle with rd_addr=cur_addr and rd_num_dwords=min(eff, remaining). Load beats_left with that value, clear the timeout counter, go to COLLECT. rd_req is never asserted while busy==1.
- COLLECT, on each rd_rdy:
  - expected = cur_addr + PATTERN_OFFSET.
  - If rd_d != expected: increment err_count (saturating). If this is the first error of the run, capture first_err_addr=cur_addr and first_err_data=rd_d.
  - Then cur_addr+1 (wraps at 2^32), remaining-1, beats_left-1, and the timeout counter clears.
  - When beats_left reaches 0, go to DRAIN.
- COLLECT timeout: each cycle without rd_rdy increments the timeout counter. At TIMEOUT_CYCLES, set timeout=1 and go to FINISH.
- DRAIN: wait for busy==0 (hyper_xface finished the burst). Then go to ISSUE if remaining!=0, else to FINISH.
- FINISH (one cycle): done=1, active=0, pass = (err_count==0 && !timeout), then go to IDLE. pass, err_count, first_err_* and timeout hold until the next accepted start.
- rd_rdy outside COLLECT is ignored (no compare, no counting).
- rd_addr and rd_num_dwords hold their last values when rd_req=0.
- Start-to-first-rd_req latency is 2 cycles when busy==0.

Test Plan:
- Clean run: base_addr=1, num_dwords=8, burst_len=4, model returns rd_d=addr -> two rd_req (addr 1 and 5, rd_num_dwords=4); done pulse; pass=1, err_count=0.
- Single corruption: same run, model returns 32'hDEAD0000 at addr 6 -> pass=0, err_count=1, first_err_addr=6, first_err_data=32'hDEAD0000.
- Partial last burst and clamping: num_dwords=5, burst_len=0, then burst_len=63 -> first case issues 5 requests of 1 dword; second issues one request with rd_num_dwords=5.
- Busy gating: hold busy=1 for 20 cycles after start -> no rd_req until the cycle after busy falls; never a rd_req while busy=1.
- Timeout: the model never asserts rd_rdy -> timeout=1 after 4096 cycles, done pulse, pass=0, active=0.
- Reset mid-run plus zero length: assert reset during COLLECT -> next cycle all outputs 0 and IDLE. Then start with num_dwords=0 -> done and pass=1 with no rd_req.
